data_mem_arbiter: RTL

//  Shares the single-port data RAM between the pipeline MEM stage (CPU port, read/write) and the audio

---
 rtl/data_mem_arbiter.sv | 106 ++++++++++
 1 files changed

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares one single-port data RAM between the CPU MEM stage and the audio reader,
// one access per cycle, CPU-first with a bounded audio wait, read data returned to the issuing port.
module data_mem_arbiter #(
    parameter int AW           = 18,
    parameter int DW           = 16,
    parameter int AUD_MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          aud_req,
    input  logic [AW-1:0] aud_addr,
    output logic          aud_gnt,
    output logic          aud_rvalid,
    output logic [DW-1:0] aud_rdata,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    output logic          ram_wren,
    input  logic [DW-1:0] ram_q
);
    localparam int WW = $clog2(AUD_MAX_WAIT + 1);
    localparam logic [WW-1:0] MAX_WAIT = WW'(AUD_MAX_WAIT);

    typedef enum logic [1:0] {IDLE, ISS_CPU, ISS_AUD} state_t;

    state_t        state_q, state_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          wren_q, wren_d;
    logic          tag1_v_q, tag1_v_d, tag1_aud_q, tag1_aud_d;
    logic          tag2_v_q, tag2_v_d, tag2_aud_q, tag2_aud_d;
    logic          cpu_rvalid_q, cpu_rvalid_d, aud_rvalid_q, aud_rvalid_d;
    logic [DW-1:0] cpu_rdata_q, cpu_rdata_d, aud_rdata_q, aud_rdata_d;
    logic          cpu_elig, aud_elig, cpu_win, aud_win;

    always_comb begin
        // a request still high during its own grant cycle is the one just consumed
        cpu_elig     = cpu_req && (state_q != ISS_CPU);
        aud_elig     = aud_req && (state_q != ISS_AUD);
        aud_win      = aud_elig && ((wait_q == MAX_WAIT) || !cpu_elig);
        cpu_win      = cpu_elig && !aud_win;
        state_d      = cpu_win ? ISS_CPU : aud_win ? ISS_AUD : IDLE;
        wait_d       = (!aud_req || aud_win) ? '0 :
                       (aud_elig && (wait_q != MAX_WAIT)) ? wait_q + 1'b1 : wait_q;
        addr_d       = cpu_win ? cpu_addr : aud_win ? aud_addr : addr_q;
        wdata_d      = cpu_win ? cpu_wdata : wdata_q;
        wren_d       = cpu_win && cpu_we;
        tag1_v_d     = (cpu_win && !cpu_we) || aud_win;
        tag1_aud_d   = aud_win;
        tag2_v_d     = tag1_v_q;
        tag2_aud_d   = tag1_aud_q;
        cpu_rvalid_d = tag2_v_q && !tag2_aud_q;
        aud_rvalid_d = tag2_v_q && tag2_aud_q;
        cpu_rdata_d  = cpu_rvalid_d ? ram_q : cpu_rdata_q;
        aud_rdata_d  = aud_rvalid_d ? ram_q : aud_rdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            wait_q       <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wren_q       <= 1'b0;
            tag1_v_q     <= 1'b0;
            tag1_aud_q   <= 1'b0;
            tag2_v_q     <= 1'b0;
            tag2_aud_q   <= 1'b0;
            cpu_rvalid_q <= 1'b0;
            aud_rvalid_q <= 1'b0;
            cpu_rdata_q  <= '0;
            aud_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            wait_q       <= wait_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wren_q       <= wren_d;
            tag1_v_q     <= tag1_v_d;
            tag1_aud_q   <= tag1_aud_d;
            tag2_v_q     <= tag2_v_d;
            tag2_aud_q   <= tag2_aud_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            aud_rvalid_q <= aud_rvalid_d;
            cpu_rdata_q  <= cpu_rdata_d;
            aud_rdata_q  <= aud_rdata_d;
        end
    end

    assign cpu_gnt    = (state_q == ISS_CPU);
    assign aud_gnt    = (state_q == ISS_AUD);
    assign cpu_rvalid = cpu_rvalid_q;
    assign aud_rvalid = aud_rvalid_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign aud_rdata  = aud_rdata_q;
    assign ram_addr   = addr_q;
    assign ram_wdata  = wdata_q;
    assign ram_wren   = wren_q;
endmodule
